// File: rtl/ad9364_rx_pattern_check.sv
// Loopback checker for the AD9364 1R1T receive stream: aligns to a repeating
// 3-entry I/Q pattern and reports lock, phase, error/sample counts and stalls.
module ad9364_rx_pattern_check #(
    parameter logic [11:0] PAT_I0       = 12'o3777,
    parameter logic [11:0] PAT_I1       = 12'o0000,
    parameter logic [11:0] PAT_I2       = 12'o4000,
    parameter logic [11:0] PAT_Q0       = 12'o3737,
    parameter logic [11:0] PAT_Q1       = 12'o1737,
    parameter logic [11:0] PAT_Q2       = 12'o0000,
    parameter int          LOCK_COUNT   = 8,
    parameter int          UNLOCK_COUNT = 4,
    parameter int          STALL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        adc_valid,
    input  logic [11:0] adc_data_i1,
    input  logic [11:0] adc_data_q1,
    input  logic        adc_status,
    input  logic        chk_clr,
    output logic        chk_locked,
    output logic [1:0]  chk_phase,
    output logic        chk_err_pulse,
    output logic [15:0] chk_err_cnt,
    output logic [31:0] chk_smp_cnt,
    output logic        chk_stall
);

    localparam logic [7:0]  LOCK_N   = 8'(LOCK_COUNT);
    localparam logic [7:0]  UNLOCK_N = 8'(UNLOCK_COUNT);
    localparam logic [15:0] STALL_N  = 16'(STALL_CYCLES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_phase;
    logic [1:0]  w_phase_nxt;
    logic [7:0]  r_run;
    logic [7:0]  w_run_nxt;
    logic [7:0]  r_miss;
    logic [7:0]  w_miss_nxt;
    logic [15:0] r_stall_cnt;
    logic [15:0] w_stall_cnt_nxt;
    logic        w_stall_nxt;
    logic        w_stall_hit;
    logic        w_err;
    logic        w_smp;
    logic [2:0]  w_hit;
    logic        w_exp_hit;
    logic [1:0]  w_phase_adv;

    assign w_hit[0] = (adc_data_i1 == PAT_I0) && (adc_data_q1 == PAT_Q0);
    assign w_hit[1] = (adc_data_i1 == PAT_I1) && (adc_data_q1 == PAT_Q1);
    assign w_hit[2] = (adc_data_i1 == PAT_I2) && (adc_data_q1 == PAT_Q2);

    always_comb begin
        w_exp_hit = 1'b0;
        case (r_phase)
            2'd0:    w_exp_hit = w_hit[0];
            2'd1:    w_exp_hit = w_hit[1];
            2'd2:    w_exp_hit = w_hit[2];
            default: w_exp_hit = 1'b0;
        endcase
    end

    assign w_phase_adv = (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;

    // Stall counter runs regardless of link status; it only watches the strobe.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        w_stall_nxt     = chk_stall;
        if (adc_valid) begin
            w_stall_cnt_nxt = 16'd0;
            w_stall_nxt     = 1'b0;
        end else if (r_stall_cnt != STALL_N) begin
            w_stall_cnt_nxt = r_stall_cnt + 16'd1;
            if (r_stall_cnt + 16'd1 == STALL_N)
                w_stall_nxt = 1'b1;
        end
    end

    assign w_stall_hit = !adc_valid && (w_stall_cnt_nxt == STALL_N);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_run_nxt   = r_run;
        w_miss_nxt  = r_miss;
        w_err       = 1'b0;
        w_smp       = 1'b0;
        if (!adc_status || w_stall_hit) begin
            w_state_nxt = ST_SEARCH;
        end else if (adc_valid) begin
            case (r_state)
                ST_SEARCH: begin
                    if (|w_hit) begin
                        // Lowest matching index wins.
                        if (w_hit[0])      w_phase_nxt = 2'd1;
                        else if (w_hit[1]) w_phase_nxt = 2'd2;
                        else               w_phase_nxt = 2'd0;
                        w_run_nxt   = 8'd1;
                        w_miss_nxt  = 8'd0;
                        w_state_nxt = (LOCK_N == 8'd1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (w_exp_hit) begin
                        w_run_nxt   = r_run + 8'd1;
                        w_phase_nxt = w_phase_adv;
                        if (r_run + 8'd1 == LOCK_N) begin
                            w_state_nxt = ST_LOCKED;
                            w_miss_nxt  = 8'd0;
                        end
                    end else begin
                        w_state_nxt = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    w_phase_nxt = w_phase_adv;
                    w_smp       = 1'b1;
                    if (w_exp_hit) begin
                        w_miss_nxt = 8'd0;
                    end else begin
                        w_err      = 1'b1;
                        w_miss_nxt = r_miss + 8'd1;
                        if (r_miss + 8'd1 == UNLOCK_N)
                            w_state_nxt = ST_SEARCH;
                    end
                end
                default: w_state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_SEARCH;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase       <= 2'd0;
            r_run         <= 8'd0;
            r_miss        <= 8'd0;
            r_stall_cnt   <= 16'd0;
            chk_locked    <= 1'b0;
            chk_phase     <= 2'd0;
            chk_err_pulse <= 1'b0;
            chk_err_cnt   <= 16'd0;
            chk_smp_cnt   <= 32'd0;
            chk_stall     <= 1'b0;
        end else begin
            r_phase       <= w_phase_nxt;
            r_run         <= w_run_nxt;
            r_miss        <= w_miss_nxt;
            r_stall_cnt   <= w_stall_cnt_nxt;
            chk_locked    <= (w_state_nxt == ST_LOCKED);
            chk_phase     <= w_phase_nxt;
            chk_err_pulse <= w_err;
            chk_stall     <= w_stall_nxt;
            // Clear takes priority over a coincident increment.
            if (chk_clr)
                chk_err_cnt <= 16'd0;
            else if (w_err && chk_err_cnt != 16'hFFFF)
                chk_err_cnt <= chk_err_cnt + 16'd1;
            if (chk_clr)
                chk_smp_cnt <= 32'd0;
            else if (w_smp)
                chk_smp_cnt <= chk_smp_cnt + 32'd1;
        end
    end

endmodule
